wb_result_sel: RTL and testbench

// - Writeback end of the datapath: the return path that mirrors operand selection into the ALU. Takes one retiring instruction

---
 rtl/wb_result_sel_pkg.sv | 33 +++
 rtl/wb_result_sel_if.sv | 31 +++
 rtl/wb_result_sel_load_ext.sv | 42 ++++
 rtl/wb_result_sel.sv | 170 +++++++++++++++++
 tb/tb_wb_result_sel.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_result_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_sel_pkg
// Description : Shared widths, writeback-source and load-funct3 encodings,
//               and FSM state type for the writeback result selector.
// Revision    : 1.0
// ============================================================================
package wb_result_sel_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_src_e;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_result_sel_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_sel_if
// Description : MEM -> WB instruction handoff (valid/ready plus payload).
// Revision    : 1.0
// ============================================================================
interface wb_result_sel_if;
    import wb_result_sel_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rd_addr;
    logic                  reg_write;
    wb_src_e               wb_src;
    logic [2:0]            load_funct3;

    modport master (
        output in_valid, alu_result, pc, imm, rd_addr, reg_write, wb_src, load_funct3,
        input  in_ready
    );

    modport slave (
        input  in_valid, alu_result, pc, imm, rd_addr, reg_write, wb_src, load_funct3,
        output in_ready
    );

endinterface
`default_nettype wire

// File: rtl/wb_result_sel_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_sel_load_ext
// Description : Selects the byte/half lane of an aligned load word and
//               sign- or zero-extends it according to funct3.
// Revision    : 1.0
// ============================================================================
module wb_result_sel_load_ext
    import wb_result_sel_pkg::*;
(
    input  wire logic [2:0]            funct3,
    input  wire logic [1:0]            addr_lo,
    input  wire logic [DATA_WIDTH-1:0] rdata,
    output logic      [DATA_WIDTH-1:0] ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        // Halfword lane ignores addr bit 0: misaligned halves read the aligned half.
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        ext = rdata;
        case (funct3)
            c_f3_lb:  ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            c_f3_lh:  ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            c_f3_lbu: ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            c_f3_lhu: ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default:  ext = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_result_sel.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_sel
// Description : Writeback result mux and RF write port driver; stalls loads
//               until the data-memory response, with timeout and flush drain.
// Revision    : 1.0
// ============================================================================
module wb_result_sel
    import wb_result_sel_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    wb_result_sel_if.slave             mem,
    input  wire logic                  flush,
    input  wire logic                  dmem_rvalid,
    input  wire logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                       rf_we,
    output logic      [4:0]            rf_waddr,
    output logic      [DATA_WIDTH-1:0] rf_wdata,
    output logic                       load_fault,
    output logic                       spurious_rsp
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT - 1);

    wb_state_e             r_state, w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
    logic                  r_we, w_we_nxt;
    logic [4:0]            r_waddr, w_waddr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic                  r_fault, w_fault_nxt;
    logic                  r_spur, w_spur_set;
    logic                  w_latch;

    logic [4:0]            r_rd;
    logic                  r_rw;
    logic [2:0]            r_f3;
    logic [1:0]            r_addr_lo;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_pc4;
    logic [DATA_WIDTH-1:0] w_pc4_data;
    logic [DATA_WIDTH-1:0] w_result;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_accept     = mem.in_valid && (r_state == S_IDLE);
    assign mem.in_ready = (r_state == S_IDLE);
    assign w_pc4        = mem.pc + ADDR_WIDTH'(4);

    generate
        if (DATA_WIDTH == ADDR_WIDTH) begin : g_pc_same
            assign w_pc4_data = w_pc4;
        end else if (DATA_WIDTH > ADDR_WIDTH) begin : g_pc_zext
            assign w_pc4_data = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_pc4};
        end else begin : g_pc_trunc
            assign w_pc4_data = w_pc4[DATA_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        w_result = mem.alu_result;
        case (mem.wb_src)
            WB_PC4:  w_result = w_pc4_data;
            WB_IMM:  w_result = mem.imm;
            default: w_result = mem.alu_result;
        endcase
    end

    wb_result_sel_load_ext u_load_ext (
        .funct3  (r_f3),
        .addr_lo (r_addr_lo),
        .rdata   (dmem_rdata),
        .ext     (w_ext)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_fault_nxt = 1'b0;
        w_spur_set  = 1'b0;
        w_latch     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_spur_set = dmem_rvalid;
                if (w_accept && !flush) begin
                    if (mem.wb_src == WB_LOAD) begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAIT;
                    end else if (mem.reg_write && (mem.rd_addr != 5'd0)) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = mem.rd_addr;
                        w_wdata_nxt = w_result;
                    end
                end
            end
            S_WAIT: begin
                // Flush beats a same-cycle response: the response is consumed unwritten.
                if (flush) begin
                    w_state_nxt = dmem_rvalid ? S_IDLE : S_DRAIN;
                end else if (dmem_rvalid) begin
                    w_state_nxt = S_IDLE;
                    if (r_rw && (r_rd != 5'd0)) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = r_rd;
                        w_wdata_nxt = w_ext;
                    end
                end else if (r_cnt == c_cnt_max) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (dmem_rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_fault   <= 1'b0;
            r_spur    <= 1'b0;
            r_rd      <= '0;
            r_rw      <= 1'b0;
            r_f3      <= '0;
            r_addr_lo <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_fault <= w_fault_nxt;
            if (w_spur_set) begin
                r_spur <= 1'b1;
            end
            if (w_latch) begin
                r_rd      <= mem.rd_addr;
                r_rw      <= mem.reg_write;
                r_f3      <= mem.load_funct3;
                r_addr_lo <= mem.alu_result[1:0];
            end
        end
    end

    assign rf_we        = r_we;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = r_wdata;
    assign load_fault   = r_fault;
    assign spurious_rsp = r_spur;

endmodule
`default_nettype wire

// File: tb/tb_wb_result_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_result_sel
// Description : Self-checking bench: vector table, random ops against a
//               reference model, and hand sequences for load stalls/flush.
// Revision    : 1.0
// ============================================================================
module tb_wb_result_sel;
    import wb_result_sel_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        load_fault;
    logic        spurious_rsp;

    int errors = 0;
    int checks = 0;

    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    wb_result_sel_if mem_if ();

    wb_result_sel #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (mem_if.slave),
        .flush        (flush),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .load_fault   (load_fault),
        .spurious_rsp (spurious_rsp)
    );

    typedef struct {
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        int          delay;
        logic        exp_we;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_if.in_valid    = 1'b0;
        mem_if.alu_result  = '0;
        mem_if.pc          = '0;
        mem_if.imm         = '0;
        mem_if.rd_addr     = '0;
        mem_if.reg_write   = 1'b0;
        mem_if.wb_src      = WB_ALU;
        mem_if.load_funct3 = '0;
        flush              = 1'b0;
        dmem_rvalid        = 1'b0;
        dmem_rdata         = '0;
    endtask

    task automatic drive_op(input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                            input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                            input logic rw);
        mem_if.in_valid    = 1'b1;
        mem_if.wb_src      = wb_src_e'(src);
        mem_if.load_funct3 = f3;
        mem_if.alu_result  = alu;
        mem_if.pc          = pc;
        mem_if.imm         = imm;
        mem_if.rd_addr     = rd;
        mem_if.reg_write   = rw;
    endtask

    // Reference writeback: returns {write_enable, data}, derived by plain shifts/arithmetic.
    function automatic logic [32:0] ref_wb(input logic [1:0] src, input logic [2:0] f3,
                                           input logic [31:0] alu, input logic [31:0] pc,
                                           input logic [31:0] imm, input logic [31:0] rdata,
                                           input logic [4:0] rd, input logic rw);
        logic [31:0] d, b, h;
        int sh;
        sh = 8 * int'(alu[1:0]);
        b  = (rdata >> sh) & 32'h0000_00FF;
        h  = alu[1] ? (rdata >> 16) : (rdata & 32'h0000_FFFF);
        case (src)
            2'd0: d = alu;
            2'd2: d = pc + 32'd4;
            2'd3: d = imm;
            default: begin
                case (f3)
                    3'd0: d = (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
                    3'd1: d = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
                    3'd4: d = b;
                    3'd5: d = h;
                    default: d = rdata;
                endcase
            end
        endcase
        return {(rw && (rd != 5'd0)), d};
    endfunction

    // Called on a negedge with the block idle; returns on the negedge after the write cycle.
    task automatic do_op(input string name, input logic [1:0] src, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
                         input int delay, input logic exp_we, input logic [31:0] exp_d);
        drive_op(src, f3, alu, pc, imm, rd, rw);
        @(negedge clk);
        mem_if.in_valid = 1'b0;
        if (src == 2'd1) begin
            for (int i = 0; i < delay; i++) begin
                chk({name, " stall ready"}, {31'd0, mem_if.in_ready}, 32'd0);
                @(negedge clk);
            end
            chk({name, " ready at rsp"}, {31'd0, mem_if.in_ready}, 32'd0);
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            @(negedge clk);
            dmem_rvalid = 1'b0;
        end
        chk({name, " rf_we"}, {31'd0, rf_we}, {31'd0, exp_we});
        if (exp_we) begin
            m_waddr = rd;
            m_wdata = exp_d;
        end
        chk({name, " waddr"}, {27'd0, rf_waddr}, {27'd0, m_waddr});
        chk({name, " wdata"}, rf_wdata, m_wdata);
        chk({name, " ready after"}, {31'd0, mem_if.in_ready}, 32'd1);
    endtask

    task automatic load_accept(input logic [31:0] alu, input logic [4:0] rd);
        drive_op(2'd1, 3'd2, alu, 32'd0, 32'd0, rd, 1'b1);
        @(negedge clk);
        mem_if.in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f3_set [8];
        logic [32:0] r;
        logic [1:0]  rsrc;
        logic [2:0]  rf3;
        logic [31:0] ralu, rpc, rimm, rdat;
        logic [4:0]  rrd;
        logic        rrw;
        f3_set = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        //        src  f3   alu           pc            imm           rdata         rd  rw d we exp
        vecs[0]  = '{2'd0, 3'd0, 32'h0000_1234, 32'h0,        32'h0,        32'h0,        5'd5,  1'b1, 0, 1'b1, 32'h0000_1234};
        vecs[1]  = '{2'd2, 3'd0, 32'h0,        32'hFFFF_FFFC, 32'h0,        32'h0,        5'd1,  1'b1, 0, 1'b1, 32'h0000_0000};
        vecs[2]  = '{2'd2, 3'd0, 32'h0,        32'h0000_1000, 32'h0,        32'h0,        5'd0,  1'b1, 0, 1'b0, 32'h0};
        vecs[3]  = '{2'd3, 3'd0, 32'h0000_5555, 32'h0,        32'hABCD_E000, 32'h0,        5'd7,  1'b1, 0, 1'b1, 32'hABCD_E000};
        vecs[4]  = '{2'd0, 3'd0, 32'h0000_9999, 32'h0,        32'h0,        32'h0,        5'd3,  1'b0, 0, 1'b0, 32'h0};
        vecs[5]  = '{2'd1, 3'd0, 32'h0000_1003, 32'h0,        32'h0,        32'h80FF_0000, 5'd8,  1'b1, 0, 1'b1, 32'hFFFF_FF80};
        vecs[6]  = '{2'd1, 3'd4, 32'h0000_1003, 32'h0,        32'h0,        32'h80FF_0000, 5'd9,  1'b1, 1, 1'b1, 32'h0000_0080};
        vecs[7]  = '{2'd1, 3'd1, 32'h0000_1002, 32'h0,        32'h0,        32'h80FF_0000, 5'd10, 1'b1, 2, 1'b1, 32'hFFFF_80FF};
        vecs[8]  = '{2'd1, 3'd5, 32'h0000_1002, 32'h0,        32'h0,        32'h80FF_0000, 5'd11, 1'b1, 2, 1'b1, 32'h0000_80FF};
        vecs[9]  = '{2'd1, 3'd2, 32'h0000_1003, 32'h0,        32'h0,        32'h80FF_0000, 5'd12, 1'b1, 0, 1'b1, 32'h80FF_0000};
        vecs[10] = '{2'd1, 3'd1, 32'h0000_1003, 32'h0,        32'h0,        32'h80FF_0000, 5'd13, 1'b1, 1, 1'b1, 32'hFFFF_80FF};
        vecs[11] = '{2'd1, 3'd0, 32'h0000_1001, 32'h0,        32'h0,        32'h1234_5678, 5'd14, 1'b1, 0, 1'b1, 32'h0000_0056};
        vecs[12] = '{2'd1, 3'd3, 32'h0000_1000, 32'h0,        32'h0,        32'hDEAD_BEEF, 5'd15, 1'b1, 0, 1'b1, 32'hDEAD_BEEF};
        vecs[13] = '{2'd1, 3'd2, 32'h0000_1000, 32'h0,        32'h0,        32'hCAFE_F00D, 5'd0,  1'b1, 0, 1'b0, 32'h0};
        vecs[14] = '{2'd1, 3'd4, 32'h0000_1000, 32'h0,        32'h0,        32'h0000_00F0, 5'd16, 1'b1, 0, 1'b1, 32'h0000_00F0};
        vecs[15] = '{2'd2, 3'd0, 32'h0,        32'h0000_0010, 32'h0,        32'h0,        5'd17, 1'b1, 0, 1'b1, 32'h0000_0014};

        idle_inputs();
        rst = 1'b1;
        m_waddr = '0;
        m_wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", {31'd0, mem_if.in_ready}, 32'd1);
        chk("reset rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        chk("reset load_fault", {31'd0, load_fault}, 32'd0);
        chk("reset spurious", {31'd0, spurious_rsp}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].src, vecs[i].f3, vecs[i].alu, vecs[i].pc,
                  vecs[i].imm, vecs[i].rdata, vecs[i].rd, vecs[i].rw, vecs[i].delay,
                  vecs[i].exp_we, vecs[i].exp_d);
        end

        // Back-to-back single-cycle ops
        drive_op(2'd0, 3'd0, 32'h0000_1234, 32'd0, 32'd0, 5'd5, 1'b1);
        @(negedge clk);
        chk("b2b first we", {31'd0, rf_we}, 32'd1);
        chk("b2b first waddr", {27'd0, rf_waddr}, 32'd5);
        chk("b2b first wdata", rf_wdata, 32'h0000_1234);
        drive_op(2'd3, 3'd0, 32'd0, 32'd0, 32'h0000_5678, 5'd6, 1'b1);
        @(negedge clk);
        mem_if.in_valid = 1'b0;
        chk("b2b second we", {31'd0, rf_we}, 32'd1);
        chk("b2b second waddr", {27'd0, rf_waddr}, 32'd6);
        chk("b2b second wdata", rf_wdata, 32'h0000_5678);
        @(negedge clk);
        chk("b2b idle we", {31'd0, rf_we}, 32'd0);
        chk("b2b hold wdata", rf_wdata, 32'h0000_5678);
        m_waddr = 5'd6;
        m_wdata = 32'h0000_5678;

        // Randomised ops against the reference model
        for (int i = 0; i < 60; i++) begin
            rsrc = 2'($urandom_range(0, 3));
            rf3  = f3_set[$urandom_range(0, 7)];
            ralu = $urandom;
            rpc  = $urandom;
            rimm = $urandom;
            rdat = $urandom;
            rrd  = 5'($urandom_range(0, 31));
            rrw  = 1'($urandom_range(0, 1));
            r    = ref_wb(rsrc, rf3, ralu, rpc, rimm, rdat, rrd, rrw);
            do_op($sformatf("rand%0d", i), rsrc, rf3, ralu, rpc, rimm, rdat, rrd, rrw,
                  int'($urandom_range(0, 6)), r[32], r[31:0]);
        end

        // Load timeout: 16 silent wait cycles, then fault pulse and drain
        load_accept(32'h0000_2000, 5'd9);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("timeout pre fault %0d", i), {31'd0, load_fault}, 32'd0);
            chk($sformatf("timeout stall %0d", i), {31'd0, mem_if.in_ready}, 32'd0);
            @(negedge clk);
        end
        chk("timeout fault pulse", {31'd0, load_fault}, 32'd1);
        chk("timeout no write", {31'd0, rf_we}, 32'd0);
        chk("timeout drain ready", {31'd0, mem_if.in_ready}, 32'd0);
        @(negedge clk);
        chk("timeout fault one cycle", {31'd0, load_fault}, 32'd0);
        chk("timeout still drain", {31'd0, mem_if.in_ready}, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("drain discard we", {31'd0, rf_we}, 32'd0);
        chk("drain back idle", {31'd0, mem_if.in_ready}, 32'd1);
        chk("drain no spurious", {31'd0, spurious_rsp}, 32'd0);
        chk("drain hold wdata", rf_wdata, m_wdata);

        // Flush in S_IDLE drops the accepted op
        drive_op(2'd0, 3'd0, 32'h0000_AAAA, 32'd0, 32'd0, 5'd20, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        drive_op(2'd1, 3'd2, 32'h0000_3000, 32'd0, 32'd0, 5'd21, 1'b1);
        chk("idle flush no write", {31'd0, rf_we}, 32'd0);
        chk("idle flush hold waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
        @(negedge clk);
        flush = 1'b0;
        mem_if.in_valid = 1'b0;
        chk("idle flush load dropped", {31'd0, mem_if.in_ready}, 32'd1);

        // Flush in S_WAIT without a response goes to drain
        load_accept(32'h0000_3000, 5'd22);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("wait flush to drain", {31'd0, mem_if.in_ready}, 32'd0);
        @(negedge clk);
        chk("wait flush drain hold", {31'd0, mem_if.in_ready}, 32'd0);
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("wait flush drained we", {31'd0, rf_we}, 32'd0);
        chk("wait flush drained ready", {31'd0, mem_if.in_ready}, 32'd1);

        // Flush and response in the same S_WAIT cycle
        load_accept(32'h0000_4000, 5'd23);
        flush       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5A5A_5A5A;
        @(negedge clk);
        flush       = 1'b0;
        dmem_rvalid = 1'b0;
        chk("flush+rsp no write", {31'd0, rf_we}, 32'd0);
        chk("flush+rsp idle", {31'd0, mem_if.in_ready}, 32'd1);
        chk("flush+rsp no spurious", {31'd0, spurious_rsp}, 32'd0);
        chk("flush+rsp no fault", {31'd0, load_fault}, 32'd0);

        // Async reset mid-load, then the late response is spurious
        load_accept(32'h0000_5000, 5'd24);
        chk("pre-rst stall", {31'd0, mem_if.in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async rst idle", {31'd0, mem_if.in_ready}, 32'd1);
        m_waddr = '0;
        m_wdata = '0;
        chk("async rst waddr", {27'd0, rf_waddr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk("late rsp spurious", {31'd0, spurious_rsp}, 32'd1);
        chk("late rsp no write", {31'd0, rf_we}, 32'd0);
        do_op("post-spurious alu", 2'd0, 3'd0, 32'h0000_0042, 32'd0, 32'd0, 32'd0,
              5'd25, 1'b1, 0, 1'b1, 32'h0000_0042);
        chk("spurious sticky", {31'd0, spurious_rsp}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("spurious cleared by rst", {31'd0, spurious_rsp}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
